// File: rtl/mult_datapath_if.sv
// mult_datapath_if: handshake and data bundle between the A/B/Op controller
// and the multiply datapath.
//   master : controller side, drives habA/habB/habOp and in_a/in_b,
//            observes fimA/fimB/fimOp and result
//   slave  : datapath side, the mirror image
// Parameter WIDTH sets the operand width; result is 2*WIDTH bits.
interface mult_datapath_if #(parameter int WIDTH = 8);
    logic               habA;
    logic               habB;
    logic               habOp;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               fimA;
    logic               fimB;
    logic               fimOp;
    logic [2*WIDTH-1:0] result;

    modport master (output habA, habB, habOp, in_a, in_b,
                    input  fimA, fimB, fimOp, result);
    modport slave  (input  habA, habB, habOp, in_a, in_b,
                    output fimA, fimB, fimOp, result);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: responder beside the A/B/Op controller FSM.
//   habA/habB load the operand registers and are answered by fimA/fimB.
//   habOp runs a fixed-latency shift-add multiply of reg_a*reg_b and is
//   answered by fimOp with the product on result.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mult_datapath_if.slave (hab*, in_a/in_b in; fim*, result out)
// Parameter WIDTH: operand width; multiply takes exactly WIDTH cycles.
// Build option SIGNED_MUL_EN: operands are two's complement; magnitudes
// are multiplied and the product is negated as it is written to result.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mult_datapath_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     reg_a, reg_b;
    logic                 fim_a, fim_b, fim_op;
    logic [2*WIDTH-1:0]   acc, mcand, res;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     a_op, b_op;
    logic                 start, step, finish;

`ifdef SIGNED_MUL_EN
    logic sign;
    // Magnitudes are exact in WIDTH unsigned bits, including the most
    // negative value.
    assign a_op = reg_a[WIDTH-1] ? -reg_a : reg_a;
    assign b_op = reg_b[WIDTH-1] ? -reg_b : reg_b;
`else
    assign a_op = reg_a;
    assign b_op = reg_b;
`endif

    assign start   = (state == IDLE) && bus.habOp;
    assign step    = (state == BUSY) && bus.habOp;
    assign finish  = step && (cnt == LAST);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.habOp) state_nxt = BUSY;
            // Dropping habOp mid-multiply abandons the partial product.
            BUSY:    if (!bus.habOp) state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = DONE;
            DONE:    if (!bus.habOp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            fim_a  <= 1'b0;
            fim_b  <= 1'b0;
            fim_op <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            res    <= '0;
`ifdef SIGNED_MUL_EN
            sign   <= 1'b0;
`endif
        end else begin
            // Operand registers are frozen while a multiply is in flight.
            if (state != BUSY) begin
                if (bus.habA && !fim_a) begin
                    reg_a <= bus.in_a;
                    fim_a <= 1'b1;
                end else if (!bus.habA) begin
                    fim_a <= 1'b0;
                end
                if (bus.habB && !fim_b) begin
                    reg_b <= bus.in_b;
                    fim_b <= 1'b1;
                end else if (!bus.habB) begin
                    fim_b <= 1'b0;
                end
            end

            if (start) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_op};
                mplier <= b_op;
                cnt    <= '0;
`ifdef SIGNED_MUL_EN
                sign   <= reg_a[WIDTH-1] ^ reg_b[WIDTH-1];
`endif
            end else if (step) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end

            // The last iteration's sum goes straight to result, so no extra
            // cycle is spent moving acc across.
            if (finish) begin
`ifdef SIGNED_MUL_EN
                res <= sign ? -acc_nxt : acc_nxt;
`else
                res <= acc_nxt;
`endif
            end

            fim_op <= (state_nxt == DONE);
        end
    end

    assign bus.fimA   = fim_a;
    assign bus.fimB   = fim_b;
    assign bus.fimOp  = fim_op;
    assign bus.result = res;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: randomized scoreboard bench for mult_datapath (WIDTH=8).
// The driver pushes the arithmetic product and due cycle for each multiply;
// a negedge monitor pops on every fimOp rise and checks value and latency.
module tb_mult_datapath;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [2*W-1:0] res;
        int             due;
    } exp_t;
    exp_t sbq[$];
    logic fim_prev = 1'b0;

    mult_datapath_if #(.WIDTH(W)) bus();
    mult_datapath #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer product, truncated to 2*W bits.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
`ifdef SIGNED_MUL_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[2*W-1:0];
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst && bus.fimOp && !fim_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_fimOp", 32'(bus.fimOp), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", 32'(bus.result), 32'(e.res));
                chk("latency", 32'(cyc), 32'(e.due));
            end
        end
        fim_prev <= bus.fimOp;
    end

    task automatic load(input bit do_a, input bit do_b, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.habA = do_a; bus.in_a = a;
        bus.habB = do_b; bus.in_b = b;
        @(negedge clk);
        if (do_a) chk("fimA_set", 32'(bus.fimA), 32'd1);
        if (do_b) chk("fimB_set", 32'(bus.fimB), 32'd1);
        bus.habA = 1'b0; bus.habB = 1'b0;
        @(negedge clk);
        chk("fim_clear", {30'd0, bus.fimA, bus.fimB}, 32'd0);
    endtask

    task automatic start_op(input logic [2*W-1:0] exp);
        exp_t e;
        e.res = exp;
        e.due = cyc + W + 1;
        sbq.push_back(e);
        bus.habOp = 1'b1;
    endtask

    task automatic finish_op(input logic [2*W-1:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            seen = bus.fimOp;
        end
        chk("fimOp_timeout", 32'(seen), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("result_hold", 32'(bus.result), 32'(exp));
        bus.habOp = 1'b0;
        @(negedge clk);
        chk("fimOp_clear", 32'(bus.fimOp), 32'd0);
    endtask

    task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] exp;
        exp = model(a, b);
        if ($urandom_range(0, 1) == 1) load(1'b1, 1'b1, a, b);
        else begin
            load(1'b1, 1'b0, a, '0);
            load(1'b0, 1'b1, '0, b);
        end
        start_op(exp);
        finish_op(exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        bus.habA = 0; bus.habB = 0; bus.habOp = 0;
        bus.in_a = '0; bus.in_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", {bus.fimA, bus.fimB, bus.fimOp, 13'd0, bus.result}, 32'd0);

        // Directed cases
        mult(8'd12, 8'd10);
        mult(8'hFF, 8'hFF);
        mult(8'h00, 8'hFF);
        mult(8'hFD, 8'h05);
        mult(8'h80, 8'h80);

        // Abort after three sampled edges: nothing may complete.
        load(1'b1, 1'b1, 8'd9, 8'd9);
        bus.habOp = 1'b1;
        repeat (3) @(negedge clk);
        bus.habOp = 1'b0;
        quiet = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.fimOp) quiet = 1'b0;
        end
        chk("abort_no_fimOp", 32'(quiet), 32'd1);
        chk("abort_result_kept", 32'(bus.result), 32'(model(8'h80, 8'h80)));
        mult(8'd3, 8'd7);

        // Reset in the middle of a multiply.
        load(1'b1, 1'b1, 8'd11, 8'd13);
        bus.habOp = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1; bus.habOp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_midop", {bus.fimA, bus.fimB, bus.fimOp, 13'd0, bus.result}, 32'd0);
        @(negedge clk);

        // Operand loads are ignored while busy.
        load(1'b1, 1'b1, 8'd5, 8'd6);
        start_op(model(8'd5, 8'd6));
        @(negedge clk);
        bus.habA = 1'b1; bus.in_a = 8'd99;
        @(negedge clk);
        chk("busy_no_loadA_1", 32'(bus.fimA), 32'd0);
        @(negedge clk);
        chk("busy_no_loadA_2", 32'(bus.fimA), 32'd0);
        bus.habA = 1'b0;
        finish_op(model(8'd5, 8'd6));
        // A stale habA must not have replaced reg_a: rerun without reloading A.
        load(1'b0, 1'b1, '0, 8'd2);
        start_op(model(8'd5, 8'd2));
        finish_op(model(8'd5, 8'd2));

        // Randomized operands
        for (int i = 0; i < 30; i++) mult(W'($urandom), W'($urandom));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
